// File: rtl/voxel_ray_sequencer.sv
// voxel_ray_sequencer: issues one DDA step at a time into the voxel core and returns a hit/miss/timeout result per ray
module voxel_ray_sequencer #(
  parameter int W = 32,
  parameter int MAX_STEPS = 96,
  parameter int STEP_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              abort,
  input  logic              ray_valid,
  output logic              ray_ready,
  input  logic [5:0]        ray_ix,
  input  logic [5:0]        ray_iy,
  input  logic [5:0]        ray_iz,
  input  logic              ray_sx,
  input  logic              ray_sy,
  input  logic              ray_sz,
  input  logic [W-1:0]      ray_next_x,
  input  logic [W-1:0]      ray_next_y,
  input  logic [W-1:0]      ray_next_z,
  input  logic [W-1:0]      ray_inc_x,
  input  logic [W-1:0]      ray_inc_y,
  input  logic [W-1:0]      ray_inc_z,
  output logic [5:0]        core_ix_in,
  output logic [5:0]        core_iy_in,
  output logic [5:0]        core_iz_in,
  output logic              core_sx_in,
  output logic              core_sy_in,
  output logic              core_sz_in,
  output logic [W-1:0]      core_next_x_in,
  output logic [W-1:0]      core_next_y_in,
  output logic [W-1:0]      core_next_z_in,
  output logic [W-1:0]      core_inc_x_in,
  output logic [W-1:0]      core_inc_y_in,
  output logic [W-1:0]      core_inc_z_in,
  output logic              core_step_valid_in,
  input  logic [5:0]        core_ix_out,
  input  logic [5:0]        core_iy_out,
  input  logic [5:0]        core_iz_out,
  input  logic [W-1:0]      core_next_x_out,
  input  logic [W-1:0]      core_next_y_out,
  input  logic [W-1:0]      core_next_z_out,
  input  logic [2:0]        core_primary_face_id_out,
  input  logic              core_out_of_bounds_out,
  input  logic              core_voxel_occupied_out,
  input  logic              core_step_valid_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic              res_timeout,
  output logic [5:0]        res_ix,
  output logic [5:0]        res_iy,
  output logic [5:0]        res_iz,
  output logic [2:0]        res_face,
  output logic [STEP_W-1:0] res_steps,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESULT, DRAIN} state_t;
  localparam logic [STEP_W-1:0] MAX = STEP_W'(MAX_STEPS);
  state_t state_q;
  logic [5:0] ix_q, iy_q, iz_q, res_ix_q, res_iy_q, res_iz_q;
  logic [W-1:0] tx_q, ty_q, tz_q, ax_q, ay_q, az_q;
  logic sx_q, sy_q, sz_q, res_hit_q, res_timeout_q;
  logic [2:0] face_q, res_face_q;
  logic [STEP_W-1:0] steps_q;
  assign core_ix_in = ix_q;
  assign core_iy_in = iy_q;
  assign core_iz_in = iz_q;
  assign core_sx_in = sx_q;
  assign core_sy_in = sy_q;
  assign core_sz_in = sz_q;
  assign core_next_x_in = tx_q;
  assign core_next_y_in = ty_q;
  assign core_next_z_in = tz_q;
  assign core_inc_x_in = ax_q;
  assign core_inc_y_in = ay_q;
  assign core_inc_z_in = az_q;
  assign core_step_valid_in = state_q == ISSUE;
  assign ray_ready = state_q == IDLE && !load_mode;
  assign res_valid = state_q == RESULT;
  assign busy = state_q != IDLE;
  assign res_hit = res_hit_q;
  assign res_timeout = res_timeout_q;
  assign res_ix = res_ix_q;
  assign res_iy = res_iy_q;
  assign res_iz = res_iz_q;
  assign res_face = res_face_q;
  assign res_steps = steps_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {ix_q, iy_q, iz_q, tx_q, ty_q, tz_q, ax_q, ay_q, az_q, sx_q, sy_q, sz_q} <= '0;
      {face_q, steps_q} <= '0;
      {res_hit_q, res_timeout_q, res_ix_q, res_iy_q, res_iz_q, res_face_q} <= '0;
    end else begin
      case (state_q)
        IDLE: if (ray_valid && !load_mode) begin
          {ix_q, iy_q, iz_q} <= {ray_ix, ray_iy, ray_iz};
          {sx_q, sy_q, sz_q} <= {ray_sx, ray_sy, ray_sz};
          {tx_q, ty_q, tz_q} <= {ray_next_x, ray_next_y, ray_next_z};
          {ax_q, ay_q, az_q} <= {ray_inc_x, ray_inc_y, ray_inc_z};
          face_q <= '0;
          steps_q <= '0;
          state_q <= ISSUE;
        end
        ISSUE: begin
          steps_q <= steps_q + STEP_W'(1);
          state_q <= abort ? DRAIN : WAIT;
        end
        WAIT: if (abort) state_q <= core_step_valid_out ? IDLE : DRAIN;
        else if (core_step_valid_out) begin
          if (core_voxel_occupied_out) begin
            {res_ix_q, res_iy_q, res_iz_q} <= {ix_q, iy_q, iz_q};
            res_face_q <= face_q;
            res_hit_q <= 1'b1;
            res_timeout_q <= 1'b0;
            state_q <= RESULT;
          end else if (core_out_of_bounds_out || steps_q == MAX) begin
            {res_ix_q, res_iy_q, res_iz_q} <= {core_ix_out, core_iy_out, core_iz_out};
            res_face_q <= core_primary_face_id_out;
            res_hit_q <= 1'b0;
            res_timeout_q <= !core_out_of_bounds_out;
            state_q <= RESULT;
          end else begin
            {ix_q, iy_q, iz_q} <= {core_ix_out, core_iy_out, core_iz_out};
            {tx_q, ty_q, tz_q} <= {core_next_x_out, core_next_y_out, core_next_z_out};
            face_q <= core_primary_face_id_out;
            state_q <= ISSUE;
          end
        end
        RESULT: if (abort || res_ready) state_q <= IDLE;
        DRAIN: if (core_step_valid_out) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_voxel_ray_sequencer.sv
// tb_voxel_ray_sequencer: directed checks of the sequencer against a behavioural 5-stage voxel core
module tb_voxel_ray_sequencer;
  typedef struct packed {
    logic v;
    logic [5:0] ix, iy, iz;
    logic [31:0] nx, ny, nz;
    logic [2:0] face;
    logic oob, occ;
  } step_t;
  logic clk, rst_n, load_mode, abort, res_ready;
  logic [5:0] rix_s, riy_s, riz_s;
  logic sx_s, sy_s, sz_s;
  logic [31:0] nx_s, ny_s, nz_s, ax_s, ay_s, az_s;
  logic rv [2];
  logic rr [2];
  logic [5:0] cix [2];
  logic [5:0] ciy [2];
  logic [5:0] ciz [2];
  logic csx [2];
  logic csy [2];
  logic csz [2];
  logic [31:0] cnx [2];
  logic [31:0] cny [2];
  logic [31:0] cnz [2];
  logic [31:0] cax [2];
  logic [31:0] cay [2];
  logic [31:0] caz [2];
  logic csv [2];
  logic rvld [2];
  logic rhit [2];
  logic rto [2];
  logic [5:0] rix [2];
  logic [5:0] riy [2];
  logic [5:0] riz [2];
  logic [2:0] rface [2];
  logic bsy [2];
  logic [6:0] rsteps0;
  logic [3:0] rsteps1;
  logic [32767:0] scene;
  step_t pipe [2][5];
  int total, passed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] idx(input logic [5:0] x, y, z);
    return {z[4:0], y[4:0], x[4:0]};
  endfunction

  function automatic step_t do_step(input logic v, input logic [5:0] x, y, z, input logic sx, sy, sz,
                                    input logic [31:0] nx, ny, nz, ax, ay, az);
    step_t r;
    r = '0;
    r.v = v;
    {r.ix, r.iy, r.iz, r.nx, r.ny, r.nz} = {x, y, z, nx, ny, nz};
    r.occ = x < 6'd32 && y < 6'd32 && z < 6'd32 && scene[idx(x, y, z)];
    if (nx <= ny && nx <= nz) begin
      r.ix = sx ? 6'(x + 6'd1) : 6'(x - 6'd1);
      r.nx = nx + ax;
      r.face = sx ? 3'd1 : 3'd2;
    end else if (ny <= nz) begin
      r.iy = sy ? 6'(y + 6'd1) : 6'(y - 6'd1);
      r.ny = ny + ay;
      r.face = sy ? 3'd3 : 3'd4;
    end else begin
      r.iz = sz ? 6'(z + 6'd1) : 6'(z - 6'd1);
      r.nz = nz + az;
      r.face = sz ? 3'd5 : 3'd6;
    end
    r.oob = r.ix > 6'd31 || r.iy > 6'd31 || r.iz > 6'd31;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 5; i++) pipe[d][i] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        pipe[d][0] <= do_step(csv[d], cix[d], ciy[d], ciz[d], csx[d], csy[d], csz[d],
                              cnx[d], cny[d], cnz[d], cax[d], cay[d], caz[d]);
        for (int i = 1; i < 5; i++) pipe[d][i] <= pipe[d][i-1];
      end
    end
  end

  voxel_ray_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .abort(abort),
    .ray_valid(rv[0]), .ray_ready(rr[0]),
    .ray_ix(rix_s), .ray_iy(riy_s), .ray_iz(riz_s), .ray_sx(sx_s), .ray_sy(sy_s), .ray_sz(sz_s),
    .ray_next_x(nx_s), .ray_next_y(ny_s), .ray_next_z(nz_s),
    .ray_inc_x(ax_s), .ray_inc_y(ay_s), .ray_inc_z(az_s),
    .core_ix_in(cix[0]), .core_iy_in(ciy[0]), .core_iz_in(ciz[0]),
    .core_sx_in(csx[0]), .core_sy_in(csy[0]), .core_sz_in(csz[0]),
    .core_next_x_in(cnx[0]), .core_next_y_in(cny[0]), .core_next_z_in(cnz[0]),
    .core_inc_x_in(cax[0]), .core_inc_y_in(cay[0]), .core_inc_z_in(caz[0]),
    .core_step_valid_in(csv[0]),
    .core_ix_out(pipe[0][4].ix), .core_iy_out(pipe[0][4].iy), .core_iz_out(pipe[0][4].iz),
    .core_next_x_out(pipe[0][4].nx), .core_next_y_out(pipe[0][4].ny), .core_next_z_out(pipe[0][4].nz),
    .core_primary_face_id_out(pipe[0][4].face), .core_out_of_bounds_out(pipe[0][4].oob),
    .core_voxel_occupied_out(pipe[0][4].occ), .core_step_valid_out(pipe[0][4].v),
    .res_valid(rvld[0]), .res_ready(res_ready), .res_hit(rhit[0]), .res_timeout(rto[0]),
    .res_ix(rix[0]), .res_iy(riy[0]), .res_iz(riz[0]), .res_face(rface[0]),
    .res_steps(rsteps0), .busy(bsy[0])
  );

  voxel_ray_sequencer #(.MAX_STEPS(8), .STEP_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .abort(abort),
    .ray_valid(rv[1]), .ray_ready(rr[1]),
    .ray_ix(rix_s), .ray_iy(riy_s), .ray_iz(riz_s), .ray_sx(sx_s), .ray_sy(sy_s), .ray_sz(sz_s),
    .ray_next_x(nx_s), .ray_next_y(ny_s), .ray_next_z(nz_s),
    .ray_inc_x(ax_s), .ray_inc_y(ay_s), .ray_inc_z(az_s),
    .core_ix_in(cix[1]), .core_iy_in(ciy[1]), .core_iz_in(ciz[1]),
    .core_sx_in(csx[1]), .core_sy_in(csy[1]), .core_sz_in(csz[1]),
    .core_next_x_in(cnx[1]), .core_next_y_in(cny[1]), .core_next_z_in(cnz[1]),
    .core_inc_x_in(cax[1]), .core_inc_y_in(cay[1]), .core_inc_z_in(caz[1]),
    .core_step_valid_in(csv[1]),
    .core_ix_out(pipe[1][4].ix), .core_iy_out(pipe[1][4].iy), .core_iz_out(pipe[1][4].iz),
    .core_next_x_out(pipe[1][4].nx), .core_next_y_out(pipe[1][4].ny), .core_next_z_out(pipe[1][4].nz),
    .core_primary_face_id_out(pipe[1][4].face), .core_out_of_bounds_out(pipe[1][4].oob),
    .core_voxel_occupied_out(pipe[1][4].occ), .core_step_valid_out(pipe[1][4].v),
    .res_valid(rvld[1]), .res_ready(res_ready), .res_hit(rhit[1]), .res_timeout(rto[1]),
    .res_ix(rix[1]), .res_iy(riy[1]), .res_iz(riz[1]), .res_face(rface[1]),
    .res_steps(rsteps1), .busy(bsy[1])
  );

  task automatic send_ray(input int d, input logic [5:0] x, y, z, input logic s);
    {rix_s, riy_s, riz_s} = {x, y, z};
    {sx_s, sy_s, sz_s} = {s, s, s};
    {nx_s, ny_s, nz_s} = {32'd1, 32'd100, 32'd100};
    {ax_s, ay_s, az_s} = {32'd1, 32'd100, 32'd100};
    rv[d] = 1'b1;
    @(negedge clk);
    rv[d] = 1'b0;
  endtask

  task automatic wait_res(input int d, output int lat);
    lat = 1;
    while (!rvld[d] && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!rvld[d]) begin
      total++;
      $display("FAIL wait_res dut%0d: res_valid never rose within %0d cycles", d, lat);
    end
  endtask

  task automatic test_reset;
    total++; if (rvld[0] !== 1'b0) $display("FAIL reset_res_valid got %b want 0", rvld[0]); else passed++;
    total++; if (bsy[0] !== 1'b0) $display("FAIL reset_busy got %b want 0", bsy[0]); else passed++;
    total++; if (csv[0] !== 1'b0) $display("FAIL reset_step_valid got %b want 0", csv[0]); else passed++;
    total++; if (rr[0] !== 1'b1) $display("FAIL reset_ray_ready got %b want 1", rr[0]); else passed++;
    total++; if ({rhit[0], rto[0], rix[0], rface[0], rsteps0} !== '0) $display("FAIL reset_res got %h want 0", {rhit[0], rto[0], rix[0], rface[0], rsteps0}); else passed++;
    total++; if ({cix[0], cnx[0], cax[0], csx[0]} !== '0) $display("FAIL reset_work got %h want 0", {cix[0], cnx[0], cax[0], csx[0]}); else passed++;
  endtask

  task automatic test_miss;
    int lat;
    scene = '0;
    send_ray(0, 6'd0, 6'd0, 6'd0, 1'b1);
    total++; if (csv[0] !== 1'b1) $display("FAIL miss_issue_strobe got %b want 1", csv[0]); else passed++;
    total++; if (bsy[0] !== 1'b1) $display("FAIL miss_busy got %b want 1", bsy[0]); else passed++;
    wait_res(0, lat);
    total++; if (lat !== 193) $display("FAIL miss_latency got %0d want 193", lat); else passed++;
    total++; if ({rhit[0], rto[0]} !== 2'b00) $display("FAIL miss_type got %b want 00", {rhit[0], rto[0]}); else passed++;
    total++; if ({rix[0], riy[0], riz[0]} !== {6'd32, 6'd0, 6'd0}) $display("FAIL miss_pos got %0d,%0d,%0d want 32,0,0", rix[0], riy[0], riz[0]); else passed++;
    total++; if (rface[0] !== 3'd1) $display("FAIL miss_face got %0d want 1", rface[0]); else passed++;
    total++; if (rsteps0 !== 7'd32) $display("FAIL miss_steps got %0d want 32", rsteps0); else passed++;
    @(negedge clk);
    total++; if ({rvld[0], bsy[0]} !== 2'b00) $display("FAIL miss_release got %b want 00", {rvld[0], bsy[0]}); else passed++;
  endtask

  task automatic test_hit;
    int lat;
    scene = '0;
    scene[idx(6'd5, 6'd0, 6'd0)] = 1'b1;
    send_ray(0, 6'd0, 6'd0, 6'd0, 1'b1);
    wait_res(0, lat);
    total++; if (lat !== 37) $display("FAIL hit_latency got %0d want 37", lat); else passed++;
    total++; if ({rhit[0], rto[0]} !== 2'b10) $display("FAIL hit_type got %b want 10", {rhit[0], rto[0]}); else passed++;
    total++; if ({rix[0], riy[0], riz[0]} !== {6'd5, 6'd0, 6'd0}) $display("FAIL hit_pos got %0d,%0d,%0d want 5,0,0", rix[0], riy[0], riz[0]); else passed++;
    total++; if (rsteps0 !== 7'd6) $display("FAIL hit_steps got %0d want 6", rsteps0); else passed++;
    total++; if (rface[0] !== 3'd1) $display("FAIL hit_face got %0d want 1", rface[0]); else passed++;
    @(negedge clk);
  endtask

  task automatic test_start_occupied;
    int lat;
    scene = '0;
    scene[idx(6'd3, 6'd3, 6'd3)] = 1'b1;
    send_ray(0, 6'd3, 6'd3, 6'd3, 1'b1);
    wait_res(0, lat);
    total++; if (lat !== 7) $display("FAIL start_latency got %0d want 7", lat); else passed++;
    total++; if (rhit[0] !== 1'b1) $display("FAIL start_hit got %b want 1", rhit[0]); else passed++;
    total++; if ({rix[0], riy[0], riz[0]} !== {6'd3, 6'd3, 6'd3}) $display("FAIL start_pos got %0d,%0d,%0d want 3,3,3", rix[0], riy[0], riz[0]); else passed++;
    total++; if (rsteps0 !== 7'd1) $display("FAIL start_steps got %0d want 1", rsteps0); else passed++;
    total++; if (rface[0] !== 3'd0) $display("FAIL start_face got %0d want 0", rface[0]); else passed++;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat;
    scene = '0;
    send_ray(1, 6'd0, 6'd0, 6'd0, 1'b1);
    wait_res(1, lat);
    total++; if (lat !== 49) $display("FAIL timeout_latency got %0d want 49", lat); else passed++;
    total++; if ({rhit[1], rto[1]} !== 2'b01) $display("FAIL timeout_type got %b want 01", {rhit[1], rto[1]}); else passed++;
    total++; if (rsteps1 !== 4'd8) $display("FAIL timeout_steps got %0d want 8", rsteps1); else passed++;
    total++; if (rix[1] !== 6'd8) $display("FAIL timeout_ix got %0d want 8", rix[1]); else passed++;
    total++; if (rface[1] !== 3'd1) $display("FAIL timeout_face got %0d want 1", rface[1]); else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort_wait;
    int lat;
    scene = '0;
    send_ray(0, 6'd0, 6'd0, 6'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if ({bsy[0], rr[0]} !== 2'b10) $display("FAIL drain_t4 got busy,ready=%b want 10", {bsy[0], rr[0]}); else passed++;
    @(negedge clk);
    total++; if (rr[0] !== 1'b0) $display("FAIL drain_t5_ready got %b want 0", rr[0]); else passed++;
    @(negedge clk);
    total++; if ({bsy[0], rr[0]} !== 2'b10) $display("FAIL drain_t6 got busy,ready=%b want 10", {bsy[0], rr[0]}); else passed++;
    @(negedge clk);
    total++; if ({bsy[0], rr[0]} !== 2'b01) $display("FAIL drain_t7 got busy,ready=%b want 01", {bsy[0], rr[0]}); else passed++;
    send_ray(0, 6'd2, 6'd0, 6'd0, 1'b0);
    wait_res(0, lat);
    total++; if (lat !== 19) $display("FAIL post_abort_latency got %0d want 19", lat); else passed++;
    total++; if ({rhit[0], rto[0], rix[0], rface[0], rsteps0} !== {2'b00, 6'd63, 3'd2, 7'd3})
      $display("FAIL post_abort_res got hit=%b to=%b ix=%0d face=%0d steps=%0d want 0 0 63 2 3", rhit[0], rto[0], rix[0], rface[0], rsteps0); else passed++;
    @(negedge clk);
  endtask

  task automatic test_abort_issue;
    send_ray(0, 6'd0, 6'd0, 6'd0, 1'b1);
    total++; if (csv[0] !== 1'b1) $display("FAIL abort_issue_strobe got %b want 1", csv[0]); else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if ({bsy[0], csv[0]} !== 2'b10) $display("FAIL abort_issue_t2 got busy,strobe=%b want 10", {bsy[0], csv[0]}); else passed++;
    repeat (4) @(negedge clk);
    total++; if (bsy[0] !== 1'b1) $display("FAIL abort_issue_t6 busy got %b want 1", bsy[0]); else passed++;
    @(negedge clk);
    total++; if (bsy[0] !== 1'b0) $display("FAIL abort_issue_t7 busy got %b want 0", bsy[0]); else passed++;
  endtask

  task automatic test_backpressure;
    int lat;
    scene = '0;
    scene[idx(6'd3, 6'd3, 6'd3)] = 1'b1;
    load_mode = 1'b1;
    @(negedge clk);
    total++; if (rr[0] !== 1'b0) $display("FAIL load_ready got %b want 0", rr[0]); else passed++;
    rv[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++; if (bsy[0] !== 1'b0) $display("FAIL load_ignore busy got %b want 0", bsy[0]); else passed++;
    end
    rv[0] = 1'b0;
    load_mode = 1'b0;
    res_ready = 1'b0;
    send_ray(0, 6'd3, 6'd3, 6'd3, 1'b1);
    wait_res(0, lat);
    repeat (10) begin
      @(negedge clk);
      total++; if ({rvld[0], rhit[0], rto[0], rix[0], riy[0], riz[0], rface[0], rsteps0, csv[0]} !==
                   {3'b110, 6'd3, 6'd3, 6'd3, 3'd0, 7'd1, 1'b0})
        $display("FAIL hold v=%b hit=%b to=%b pos=%0d,%0d,%0d face=%0d steps=%0d strobe=%b want 1 1 0 3,3,3 0 1 0",
                 rvld[0], rhit[0], rto[0], rix[0], riy[0], riz[0], rface[0], rsteps0, csv[0]); else passed++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if ({rvld[0], bsy[0]} !== 2'b00) $display("FAIL abort_result got %b want 00", {rvld[0], bsy[0]}); else passed++;
    res_ready = 1'b1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    scene = '0;
    rst_n = 1'b0;
    load_mode = 1'b0;
    abort = 1'b0;
    res_ready = 1'b1;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    {rix_s, riy_s, riz_s, sx_s, sy_s, sz_s, nx_s, ny_s, nz_s, ax_s, ay_s, az_s} = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_miss;
    test_hit;
    test_start_occupied;
    test_timeout;
    test_abort_wait;
    test_abort_issue;
    test_backpressure;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/voxel_ray_sequencer.md
# voxel_ray_sequencer

Per-ray traversal controller for `voxel_raytracer_core`. It accepts one ray-setup packet through a valid/ready handshake and holds the ray's constants on the core's step inputs. It issues one step at a time into the core's 5-cycle pipeline and feeds each step result back as the next step's input. It stops on a hit, an out-of-bounds step or a step budget, then presents a single result packet. It also blocks new rays while the scene is loading and provides a synchronous abort that drains any in-flight core step.

## Interface
- `W`, 32: timer width; must match the core.
- `MAX_STEPS`, 96: step budget per ray (≥ 3·31 covers any 32³ traversal).
- `STEP_W`, 7: step counter width; must satisfy 2^STEP_W > MAX_STEPS.

Ports (clock and reset first):
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_mode` in 1: scene loading active; new rays are refused.
- `abort` in 1: synchronous ray cancel.
- `ray_valid` in 1, `ray_ready` out 1: ray-setup handshake.
- `ray_ix`/`ray_iy`/`ray_iz` in 6 each: start voxel.
- `ray_sx`/`ray_sy`/`ray_sz` in 1 each: step direction per axis.
- `ray_next_x`/`y`/`z` in W each: initial timers.
- `ray_inc_x`/`y`/`z` in W each: timer increments.
- `core_ix_in`/`iy_in`/`iz_in` out 6, `core_sx_in`/`sy_in`/`sz_in` out 1, `core_next_*_in` out W, `core_inc_*_in` out W: driven into the core.
- `core_step_valid_in` out 1: step issue strobe.
- `core_ix_out`/`iy_out`/`iz_out` in 6, `core_next_*_out` in W, `core_primary_face_id_out` in 3, `core_out_of_bounds_out` in 1, `core_voxel_occupied_out` in 1, `core_step_valid_out` in 1: returned from the core.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_hit` out 1, `res_timeout` out 1: termination type.
- `res_ix`/`res_iy`/`res_iz` out 6: result voxel.
- `res_face` out 3: face of entry into the result voxel.
- `res_steps` out STEP_W: number of steps issued for this ray.
- `busy` out 1: state ≠ IDLE.

## Operation
The FSM has five states: IDLE, ISSUE, WAIT, RESULT, DRAIN.

Working registers:
- `pos` (3×6 bits), `tmr` (3×W), `sgn` (3), `inc` (3×W).
- `last_face` (3 bits), `steps` (STEP_W bits).

Core inputs:
- `core_*_in` are driven combinationally from the working registers at all times.
- `core_step_valid_in` = (state == ISSUE).

State behaviour:
- **IDLE:** `ray_ready` = !`load_mode`. When `ray_valid` && `ray_ready`, load all working registers from the `ray_*` inputs, clear `last_face` and `steps`, and go to ISSUE.
- **ISSUE:** lasts exactly one cycle. `steps` += 1. Go to WAIT.
- **WAIT:** hold until `core_step_valid_out`, then evaluate in this priority order:
  1. `core_voxel_occupied_out`: hit. `res_*` pos = `pos` (the voxel just issued), `res_face` = `last_face`. Go to RESULT.
  2. else `core_out_of_bounds_out`: miss. `res_*` pos = `core_i*_out` (the out-of-range coordinate), `res_face` = `core_primary_face_id_out`. Go to RESULT.
  3. else `steps` == MAX_STEPS: timeout. `res_*` pos = `core_i*_out`, `res_face` = `core_primary_face_id_out`, `res_timeout` = 1. Go to RESULT.
  4. else continue: `pos` ← `core_i*_out`, `tmr` ← `core_next_*_out`, `last_face` ← `core_primary_face_id_out`. Go to ISSUE.
- **RESULT:** `res_valid` = 1. All `res_*` outputs are held stable until `res_ready`, then go to IDLE.
- **DRAIN:** `ray_ready` = 0. Wait for `core_step_valid_out`, discard it, and go to IDLE.

Abort (`abort` = 1) by state:
- IDLE: no effect.
- ISSUE: the strobe is still asserted that cycle; go to DRAIN.
- WAIT: if `core_step_valid_out` is also high that cycle, discard it and go to IDLE; otherwise go to DRAIN.
- RESULT: drop the result and go to IDLE.
- DRAIN: no effect.

Abort takes priority over every WAIT evaluation.

Other rules:
- `load_mode` does not affect a ray that is already in flight.
- `res_hit` and `res_timeout` are never both 1. A miss is `res_valid` with both 0.
- `res_steps` is in the range 1..MAX_STEPS.

## Timing
- Reset values: state IDLE; all `res_*` = 0; `res_valid` = 0; `busy` = 0; `core_step_valid_in` = 0; all working registers = 0. `ray_ready` = !`load_mode` (combinational).
- Ray accepted at cycle T: ISSUE at T+1, core result at T+6, WAIT evaluates at T+6.
- Continuing steps re-ISSUE at T+7, so each step costs 6 cycles.
- A ray that terminates after k steps has `res_valid` first high at T+1+6k.
- `res_valid` → IDLE takes 1 cycle. The next ray can be accepted the cycle after RESULT is left.
- At most one core step is in flight at any time, so no stale response can reach a new ray.

## Test plan
- **Empty scene, +x ray.** Start (0,0,0), sx=1, next=(1,100,100), inc=(1,100,100). Expect miss: `res_ix`=32, `res_steps`=32, `res_face` = the core's x-face id, `res_valid` at T+193.
- **Hit.** Load only (5,0,0), then run the +x ray. Expect `res_hit`=1, pos (5,0,0), `res_steps`=6, `res_face` = the face id reported on step 5.
- **Start voxel occupied.** Load (3,3,3) and start there. Expect `res_hit`=1, `res_steps`=1, `res_face`=0, `res_valid` at T+7.
- **Timeout.** MAX_STEPS=8, empty scene, +x ray. Expect `res_timeout`=1, `res_steps`=8, `res_ix`=8.
- **Abort and drain.** Assert abort at T+3 (WAIT). Expect DRAIN until T+6, `ray_ready`=0 through T+6. A new ray accepted at T+7 must give a correct result, unaffected by the dropped step.
- **Load-mode blocking and result backpressure.** With `load_mode`=1, expect `ray_ready`=0 and `ray_valid` ignored. With `res_ready`=0 for 10 cycles in RESULT, all `res_*` outputs must stay stable and no `core_step_valid_in` may be issued.
